btn_cmd_gen: RTL and testbench

BTN_CMD_GEN -- requirements
Module: btn_cmd_gen

---
 rtl/btn_cmd_gen_pkg.sv | 33 +++
 rtl/btn_cmd_gen_if.sv | 28 ++
 rtl/btn_cmd_gen_repeat_timer.sv | 83 ++++++++
 rtl/btn_cmd_gen.sv | 84 ++++++++
 tb/tb_btn_cmd_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/btn_cmd_gen_pkg.sv
// Shared encodings and defaults for the button-to-command generator.
// Direction codes, repeat-timer states, default timing and counter width.
package btn_cmd_pkg;

   localparam int CNT_W              = 26;
   localparam int HOLD_DELAY_DEF     = 30_000_000;
   localparam int REPEAT_PERIOD_DEF  = 10_000_000;

   typedef logic [2:0] dir_t;

   localparam dir_t DIR_NONE  = 3'd0;
   localparam dir_t DIR_UP    = 3'd1;
   localparam dir_t DIR_DOWN  = 3'd2;
   localparam dir_t DIR_LEFT  = 3'd3;
   localparam dir_t DIR_RIGHT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD_WAIT,
      ST_REPEAT
   } rpt_state_t;

   // Fixed priority UP > DOWN > LEFT > RIGHT.
   function automatic dir_t pick_dir(input logic up, input logic down,
                                     input logic left, input logic right);
      if (up)         return DIR_UP;
      else if (down)  return DIR_DOWN;
      else if (left)  return DIR_LEFT;
      else if (right) return DIR_RIGHT;
      else            return DIR_NONE;
   endfunction

endpackage

// File: rtl/btn_cmd_gen_if.sv
// Command channel: valid/ready handshake carrying a move and a bomb flag.
// cmd_drop flags a direction event lost while the channel was stalled.
interface btn_cmd_gen_if;
   import btn_cmd_pkg::*;

   logic cmd_valid;
   dir_t cmd_dir;
   logic cmd_bomb;
   logic cmd_ready;
   logic cmd_drop;

   modport master (
      output cmd_valid,
      output cmd_dir,
      output cmd_bomb,
      output cmd_drop,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_dir,
      input  cmd_bomb,
      input  cmd_drop,
      output cmd_ready
   );

endinterface

// File: rtl/btn_cmd_gen_repeat_timer.sv
// Direction press / hold / auto-repeat timer; dir_evt is combinational from the current
// inputs and state, so the command register sees it on the same edge. No backpressure.
module repeat_timer
   import btn_cmd_pkg::*;
#(
   parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic the_clk,
   input  logic rst_n,
   input  logic arm,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   output logic dir_evt,
   output dir_t dir_sel
);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

   rpt_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dir_t             dir_q, dir_d;
   dir_t             act;

   assign act     = pick_dir(btn_up, btn_down, btn_left, btn_right);
   assign dir_sel = act;

   always_ff @(posedge the_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= DIR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      dir_d   = dir_q;
      dir_evt = 1'b0;

      if (act == DIR_NONE) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         dir_d   = DIR_NONE;
      end else if (state_q == ST_IDLE || act != dir_q) begin
         // A fresh press or a switch of direction; suppressed on the first
         // edge after reset so a button held through reset stays silent.
         state_d = ST_HOLD_WAIT;
         cnt_d   = '0;
         dir_d   = act;
         dir_evt = arm;
      end else begin
         unique case (state_q)
            ST_HOLD_WAIT: begin
               if (cnt_q == HOLD_LAST) begin
                  dir_evt = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_REPEAT;
               end
            end
            ST_REPEAT: begin
               if (cnt_q == REPEAT_LAST) begin
                  dir_evt = 1'b1;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/btn_cmd_gen.sv
// Turns button levels into move/bomb commands, 1-cycle latency from input edge to cmd_valid.
// While stalled, a bomb merges into the pending command and a direction event is dropped.
module btn_cmd_gen
   import btn_cmd_pkg::*;
#(
   parameter int HOLD_DELAY    = HOLD_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic          the_clk,
   input  logic          rst_n,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_bomb,
   btn_cmd_gen_if.master cmd
);

   logic arm_q;
   logic bomb_q;
   logic vld_q;
   dir_t dir_q;
   logic bomb_flag_q;
   logic drop_q;

   logic dir_evt;
   dir_t dir_sel;
   logic bomb_evt;
   logic new_evt;
   logic can_load;

   repeat_timer #(
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_repeat_timer (
      .the_clk   (the_clk),
      .rst_n     (rst_n),
      .arm       (arm_q),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .dir_evt   (dir_evt),
      .dir_sel   (dir_sel)
   );

   // arm_q masks the first edge after reset so a held bomb is not an edge.
   assign bomb_evt = arm_q & btn_bomb & ~bomb_q;
   assign new_evt  = dir_evt | bomb_evt;
   assign can_load = ~vld_q | cmd.cmd_ready;

   always_ff @(posedge the_clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q       <= 1'b0;
         bomb_q      <= 1'b0;
         vld_q       <= 1'b0;
         dir_q       <= DIR_NONE;
         bomb_flag_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         arm_q  <= 1'b1;
         bomb_q <= btn_bomb;
         drop_q <= 1'b0;
         if (new_evt && can_load) begin
            vld_q       <= 1'b1;
            dir_q       <= dir_evt ? dir_sel : DIR_NONE;
            bomb_flag_q <= bomb_evt;
         end else if (new_evt) begin
            bomb_flag_q <= bomb_flag_q | bomb_evt;
            drop_q      <= dir_evt;
         end else if (vld_q && cmd.cmd_ready) begin
            vld_q       <= 1'b0;
            dir_q       <= DIR_NONE;
            bomb_flag_q <= 1'b0;
         end
      end
   end

   assign cmd.cmd_valid = vld_q;
   assign cmd.cmd_dir   = dir_q;
   assign cmd.cmd_bomb  = bomb_flag_q;
   assign cmd.cmd_drop  = drop_q;

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Bench for btn_cmd_gen with short timing: directed scenarios plus random buttons/ready,
// all checked against an elapsed-time reference model of press, hold and repeat.
module tb_btn_cmd_gen;

   localparam int HD = 4;
   localparam int RP = 2;

   logic the_clk = 1'b0;
   logic rst_n;
   logic b_up, b_down, b_left, b_right, b_bomb;
   logic rdy;

   btn_cmd_gen_if cif ();
   assign cif.cmd_ready = rdy;

   btn_cmd_gen #(
      .HOLD_DELAY    (HD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .the_clk   (the_clk),
      .rst_n     (rst_n),
      .btn_up    (b_up),
      .btn_down  (b_down),
      .btn_left  (b_left),
      .btn_right (b_right),
      .btn_bomb  (b_bomb),
      .cmd       (cif)
   );

   always #5 the_clk = ~the_clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state: held direction and the cycle it was pressed.
   int   m_held;
   int   m_start;
   int   cyc;
   logic m_prev_bomb;
   logic m_armed;
   logic m_vld;
   int   m_dir;
   logic m_bomb;
   logic m_drop;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_held      = 0;
      m_start     = 0;
      m_prev_bomb = 1'b0;
      m_armed     = 1'b0;
      m_vld       = 1'b0;
      m_dir       = 0;
      m_bomb      = 1'b0;
      m_drop      = 1'b0;
   endtask

   task automatic model_step();
      int   act;
      int   e;
      logic dir_ev;
      logic bomb_ev;
      dir_ev = 1'b0;
      act = b_up ? 1 : b_down ? 2 : b_left ? 3 : b_right ? 4 : 0;
      if (act == 0) begin
         m_held = 0;
      end else if (act != m_held) begin
         m_held  = act;
         m_start = cyc;
         dir_ev  = m_armed;
      end else begin
         e = cyc - m_start;
         dir_ev = (e == HD) || (e > HD && ((e - HD) % RP) == 0);
      end
      bomb_ev     = m_armed && b_bomb && !m_prev_bomb;
      m_prev_bomb = b_bomb;
      m_armed     = 1'b1;
      m_drop      = 1'b0;
      if (dir_ev || bomb_ev) begin
         if (!m_vld || rdy) begin
            m_vld  = 1'b1;
            m_dir  = dir_ev ? act : 0;
            m_bomb = bomb_ev;
         end else begin
            m_bomb = m_bomb | bomb_ev;
            m_drop = dir_ev;
         end
      end else if (m_vld && rdy) begin
         m_vld  = 1'b0;
         m_dir  = 0;
         m_bomb = 1'b0;
      end
      cyc++;
   endtask

   task automatic compare_all();
      chk("cmd_valid", 32'(cif.cmd_valid), 32'(m_vld));
      chk("cmd_dir",   32'(cif.cmd_dir),   32'(m_dir));
      chk("cmd_bomb",  32'(cif.cmd_bomb),  32'(m_bomb));
      chk("cmd_drop",  32'(cif.cmd_drop),  32'(m_drop));
   endtask

   task automatic run_cycles(input int n, output int ncmd, output int ndrop);
      ncmd  = 0;
      ndrop = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge the_clk);
         if (rst_n) model_step();
         @(negedge the_clk);
         compare_all();
         if (cif.cmd_valid && cif.cmd_ready) ncmd++;
         if (cif.cmd_drop) ndrop++;
      end
   endtask

   task automatic set_btns(input logic [4:0] v);
      {b_up, b_down, b_left, b_right, b_bomb} = v;
   endtask

   initial begin
      int nc;
      int nd;
      int tot;
      rst_n = 1'b0;
      rdy   = 1'b1;
      cyc   = 0;
      set_btns(5'b0);
      model_reset();
      #2;
      compare_all();
      run_cycles(2, nc, nd);
      rst_n = 1'b1;
      run_cycles(3, nc, nd);

      // Held UP: commands after edges 0, 4, 6, 8, 10.
      b_up = 1'b1;
      run_cycles(12, nc, nd);
      chk("up_hold_cmds", 32'(nc), 32'd5);
      b_up = 1'b0;
      run_cycles(6, nc, nd);
      chk("up_release_cmds", 32'(nc), 32'd0);

      // LEFT+RIGHT resolves to LEFT; releasing LEFT is a new RIGHT press.
      b_left  = 1'b1;
      b_right = 1'b1;
      run_cycles(3, nc, nd);
      b_left = 1'b0;
      run_cycles(1, nc, nd);
      chk("right_switch_dir", 32'(cif.cmd_dir), 32'd4);
      run_cycles(6, nc, nd);
      b_right = 1'b0;
      run_cycles(3, nc, nd);

      // Stalled DOWN: bomb merges, next repeat is dropped, then accept.
      rdy    = 1'b0;
      b_down = 1'b1;
      run_cycles(1, nc, nd);
      tot    = nd;
      b_bomb = 1'b1;
      run_cycles(1, nc, nd);
      tot += nd;
      chk("stall_dir_held", 32'(cif.cmd_dir), 32'd2);
      b_bomb = 1'b0;
      run_cycles(3, nc, nd);
      tot += nd;
      chk("stall_drops", 32'(tot), 32'd1);
      rdy = 1'b1;
      run_cycles(1, nc, nd);
      chk("stall_cleared", 32'(cif.cmd_valid), 32'd0);
      b_down = 1'b0;
      run_cycles(3, nc, nd);

      // Bomb held for 20 cycles gives one bomb-only command.
      b_bomb = 1'b1;
      run_cycles(20, nc, nd);
      chk("bomb_hold_cmds", 32'(nc), 32'd1);
      b_bomb = 1'b0;
      run_cycles(2, nc, nd);

      // Reset mid-REPEAT with a stalled command, then release with UP held.
      rdy  = 1'b0;
      b_up = 1'b1;
      run_cycles(7, nc, nd);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      run_cycles(2, nc, nd);
      rst_n = 1'b1;
      rdy   = 1'b1;
      run_cycles(HD, nc, nd);
      chk("rst_held_quiet", 32'(nc), 32'd0);
      run_cycles(1, nc, nd);
      chk("rst_held_first", 32'(nc), 32'd1);
      b_up = 1'b0;
      run_cycles(2, nc, nd);

      // Random buttons and ready with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)
            set_btns(5'($urandom) & 5'($urandom | 32'h1));
         rdy = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            model_reset();
            compare_all();
            run_cycles(1, nc, nd);
            rst_n = 1'b1;
         end
         run_cycles(1, nc, nd);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
